operand_packer: RTL and testbench
=================================

# operand_packer

Stream-to-vector packer that writes the packed operand bus consumed by the design's combinational adder trees. Accepts signed operands one per cycle over a valid/ready stream, assembles `NUM` of them (or fewer, on `in_last`) into one packed `NUM*IN_WIDTH` word, and presents it on a valid/ready output. Sits between serial data producers (MAC/psum streams) and an `adder_tree` instance, so element ordering matches the tree's pairing order.

## Interface
- `IN_WIDTH`, 8: width of one operand (two's complement).
- `NUM`, 4: operands per packed vector; legal range `NUM >= 1`.
- `CNT_W` (localparam), `$clog2(NUM+1)`: width of `out_count`.

- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand present.
- `in_ready`  out  1  packer can accept an operand this cycle.
- `in_data`  in  `IN_WIDTH`  operand.
- `in_last`  in  1  this operand closes the vector early; qualified by `in_valid`.
- `out_valid`  out  1  packed vector present.
- `out_ready`  in  1  consumer accepts vector.
- `out_data`  out  `NUM*IN_WIDTH`  packed vector.
- `out_count`  out  `CNT_W`  number of real operands in `out_data` (1..`NUM`).

## Operation
- Beat accepted when `in_valid && in_ready`; vector transfer when `out_valid && out_ready`.
- Slot order: k-th accepted operand of a vector (k = 0..NUM-1) goes to `out_data[(NUM-k)*IN_WIDTH-1 -: IN_WIDTH]`; first operand at MSB end, last at LSBs.
- Unfilled slots (early `in_last`) are zero, so downstream sums are unaffected.
- Vector completes on the accepted beat with slot index `NUM-1` or with `in_last=1`, whichever first. `in_last` on slot `NUM-1` is legal and redundant.
- Storage: fill buffer (`NUM` slots + slot index) and output register (`out_data`, `out_count`, `out_valid`).
- States:
  - FILL: `in_ready=1`. On a completing beat:
    - If output can load (`!out_valid || out_ready`), the merged vector loads into the output register and the fill buffer clears; stay FILL.
    - Otherwise the merged vector stays in the fill buffer; go HELD.
  - HELD: `in_ready=0`. On output transfer, fill buffer contents load into the output register (`out_valid` stays 1), fill clears, go FILL.
- `out_valid` clears on a transfer with no simultaneous load.
- Simultaneous transfer and completing beat in FILL: new vector loads that edge; no bubble.
- `NUM=1`: every accepted beat completes; `out_count` is always 1.
- `in_data`/`in_last` are ignored when `in_valid=0`.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_count=0`, `in_ready=1` (state FILL, slot index 0, fill buffer zero).
- Reset mid-fill or mid-HELD discards all partial and held data; no vector emitted.
- Latency: completing beat accepted at edge t gives `out_valid=1` with the vector in the cycle after t.
- `out_data`/`out_count` stable while `out_valid && !out_ready`.
- `in_ready` is a registered state decode (HELD), with no combinational path from `out_ready`.
- Throughput: one full vector per `NUM` cycles sustained when `out_ready=1`. One extra vector is buffered under backpressure, then input stalls.

## Structure
- Single module; no sub-module. The output register is inline.
- No shared package types required. State enum `{FILL, HELD}` is local. `CNT_W` is local.
- Slot writes use an indexed part-select into a packed `[NUM-1:0][IN_WIDTH-1:0]` fill array, reversed on output to match MSB-first order.

## Test plan
- Bench config NUM=4, IN_WIDTH=8.
- Beats 0x01,0x02,0x03,0x04 with `out_ready=1` -> `out_data=0x01020304`, `out_count=4`, `out_valid` high exactly one cycle after 4th beat.
- Beats 0xAA,0xBB(`in_last=1`) -> `out_data=0xAABB0000`, `out_count=2`; next vector starts at slot 0.
- `out_ready=0`, stream 0x10..0x17 -> first vector 0x10111213 shown, `in_ready` low after 0x17 accepted, 9th beat 0x18 not taken. Raise `out_ready` -> 0x14151617 next cycle, then `in_ready=1`.
- Accept 0x55,0x66, assert `rst` one cycle -> all outputs reset. Then 0x01..0x04 -> `0x01020304`, no trace of 0x55/0x66.
- NUM=1 build, continuous beats 0x7F,0x80,0x01 with `out_ready=1` -> outputs 0x7F,0x80,0x01 on consecutive cycles, `out_count=1`.
- Random `in_valid`/`out_ready` throttling, 10k operands, random `in_last` -> scoreboard matches order, zero padding and counts; with full-rate ready, exactly one vector per 4 cycles.

Source files
------------

// File: rtl/operand_packer.sv
// operand_packer: collects up to NUM signed operands from a valid/ready
// stream into one packed vector. The first operand lands at the MSB end.
// The output register holds one vector. When the output is blocked, one more
// completed vector is parked in the fill buffer before the input stalls.
module operand_packer #(
  parameter  int IN_WIDTH = 8,
  parameter  int NUM      = 4,
  localparam int CNT_W    = $clog2(NUM + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IN_WIDTH-1:0]     in_data,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NUM*IN_WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]        out_count
);

  localparam int SLOT_W = (NUM > 1) ? $clog2(NUM) : 1;

  typedef enum logic {
    FILL = 1'b0,
    HELD = 1'b1
  } state_e;

  state_e                         r_state, w_state_nxt;
  logic [NUM-1:0][IN_WIDTH-1:0]   r_fill, w_fill_nxt, w_merged;
  logic [SLOT_W-1:0]              r_slot, w_slot_nxt;
  logic [NUM*IN_WIDTH-1:0]        r_out_data, w_out_data_nxt;
  logic [CNT_W-1:0]               r_out_count, w_out_count_nxt;
  logic                           r_out_valid, w_out_valid_nxt;

  logic                           w_accept;
  logic                           w_complete;
  logic                           w_xfer;
  logic                           w_out_free;
  logic [CNT_W-1:0]               w_fill_count;

  // Fill slot k is stored at array index k; the output puts slot 0 at the
  // MSB end so element order matches the adder tree's pairing order.
  function automatic logic [NUM*IN_WIDTH-1:0] msb_first(
    input logic [NUM-1:0][IN_WIDTH-1:0] fill
  );
    logic [NUM*IN_WIDTH-1:0] v;
    v = '0;
    for (int k = 0; k < NUM; k++) begin
      v[(NUM-k)*IN_WIDTH-1 -: IN_WIDTH] = fill[k];
    end
    return v;
  endfunction

  assign in_ready     = (r_state == FILL);
  assign w_accept     = in_valid && (r_state == FILL);
  assign w_complete   = w_accept && (in_last || (r_slot == SLOT_W'(NUM - 1)));
  assign w_xfer       = r_out_valid && out_ready;
  assign w_out_free   = !r_out_valid || out_ready;
  assign w_fill_count = CNT_W'(r_slot) + CNT_W'(1);

  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign out_count    = r_out_count;

  // Fill buffer with the incoming operand written into the current slot.
  always_comb begin
    w_merged         = r_fill;
    w_merged[r_slot] = in_data;
  end

  // Next-state logic for the FSM, the fill buffer and the output register.
  always_comb begin
    // NOTE: every signal gets a default value first. With the defaults in
    // place, no path leaves a signal unassigned, so no latch is inferred.
    w_state_nxt     = r_state;
    w_fill_nxt      = r_fill;
    w_slot_nxt      = r_slot;
    w_out_data_nxt  = r_out_data;
    w_out_count_nxt = r_out_count;
    w_out_valid_nxt = r_out_valid;

    // The vector drains. A load below can reassert valid on the same edge.
    if (w_xfer) begin
      w_out_valid_nxt = 1'b0;
    end

    unique case (r_state)
      FILL: begin
        if (w_accept) begin
          if (w_complete && w_out_free) begin
            w_out_data_nxt  = msb_first(w_merged);
            w_out_count_nxt = w_fill_count;
            w_out_valid_nxt = 1'b1;
            w_fill_nxt      = '0;
            w_slot_nxt      = '0;
          end else if (w_complete) begin
            // Output is blocked. Park the vector here. r_slot keeps the
            // count of the parked vector.
            w_fill_nxt  = w_merged;
            w_state_nxt = HELD;
          end else begin
            w_fill_nxt = w_merged;
            w_slot_nxt = r_slot + SLOT_W'(1);
          end
        end
      end
      HELD: begin
        // out_valid is always high here, so out_ready means a transfer.
        if (out_ready) begin
          w_out_data_nxt  = msb_first(r_fill);
          w_out_count_nxt = w_fill_count;
          w_out_valid_nxt = 1'b1;
          w_fill_nxt      = '0;
          w_slot_nxt      = '0;
          w_state_nxt     = FILL;
        end
      end
      default: w_state_nxt = FILL;
    endcase
  end

  // State, fill buffer and output register, with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments. All registers
    // then update together from the values they held before the edge.
    if (rst) begin
      r_state     <= FILL;
      // NOTE: the fill buffer is reset even though it is storage. Unfilled
      // slots are emitted as zero padding, so its contents must start at zero.
      r_fill      <= '0;
      r_slot      <= '0;
      r_out_data  <= '0;
      r_out_count <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_fill      <= w_fill_nxt;
      r_slot      <= w_slot_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_count <= w_out_count_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

endmodule

// File: tb/tb_operand_packer.sv
// Bench for operand_packer. A NUM=4 instance takes directed vectors,
// hand-written backpressure and reset sequences, and random throttled
// traffic checked against a queue model. A NUM=1 instance gets a short
// sequence of its own.
module tb_operand_packer;

  logic        clk = 1'b0;
  logic        rst;

  logic        in_valid, in_ready, in_last;
  logic [7:0]  in_data;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_count;

  logic        d1_in_valid, d1_in_ready, d1_in_last;
  logic [7:0]  d1_in_data;
  logic        d1_out_valid, d1_out_ready;
  logic [7:0]  d1_out_data;
  logic [0:0]  d1_out_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  operand_packer #(.IN_WIDTH(8), .NUM(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_count(out_count)
  );

  operand_packer #(.IN_WIDTH(8), .NUM(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(d1_in_valid), .in_ready(d1_in_ready), .in_data(d1_in_data), .in_last(d1_in_last),
    .out_valid(d1_out_valid), .out_ready(d1_out_ready), .out_data(d1_out_data),
    .out_count(d1_out_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus on the NUM=4 instance. Outputs are
  // sampled 1 time unit after the edge.
  task automatic step(input logic v, input logic [7:0] d, input logic l, input logic r);
    in_valid = v; in_data = d; in_last = l; out_ready = r;
    @(posedge clk); #1;
  endtask

  // Model of the NUM=4 instance. Completed vectors wait in order in a queue.
  // The head of the queue is the vector on the output. The input stalls
  // while a second completed vector is waiting behind it.
  logic [31:0] mq_data[$];
  int          mq_cnt[$];
  logic [7:0]  part[4];
  int          part_n;
  int          ops_acc;
  int          xfer_seen;

  task automatic model_clear();
    mq_data.delete(); mq_cnt.delete();
    part_n = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    d1_in_valid = 1'b0; d1_in_last = 1'b0; d1_in_data = '0; d1_out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
  endtask

  task automatic model_cycle(input logic v, input logic [7:0] d, input logic l, input logic r);
    logic        exp_rdy, acc, xfer;
    logic [31:0] vec;
    in_valid = v; in_data = d; in_last = l; out_ready = r;
    exp_rdy = (mq_data.size() < 2);
    acc     = v && exp_rdy;
    xfer    = r && (mq_data.size() > 0);
    check("rand_in_ready", in_ready, exp_rdy);
    check("rand_out_valid", out_valid, mq_data.size() > 0);
    if (mq_data.size() > 0) begin
      check("rand_out_data", out_data, mq_data[0]);
      check("rand_out_count", out_count, mq_cnt[0]);
    end
    if (out_valid && out_ready) xfer_seen++;
    @(posedge clk); #1;
    if (xfer) begin
      void'(mq_data.pop_front());
      void'(mq_cnt.pop_front());
    end
    if (acc) begin
      part[part_n] = d;
      part_n++;
      ops_acc++;
      if (l || part_n == 4) begin
        vec = '0;
        for (int k = 0; k < part_n; k++) vec = vec | (32'(part[k]) << (8 * (3 - k)));
        mq_data.push_back(vec);
        mq_cnt.push_back(part_n);
        part_n = 0;
      end
    end
  endtask

  typedef struct {
    logic [7:0]  d;
    logic        l;
    logic        ev;
    logic [31:0] ed;
    logic [2:0]  ec;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{8'h01, 1'b0, 1'b0, 32'h0,        3'd0};
    tbl[1]  = '{8'h02, 1'b0, 1'b0, 32'h0,        3'd0};
    tbl[2]  = '{8'h03, 1'b0, 1'b0, 32'h0,        3'd0};
    tbl[3]  = '{8'h04, 1'b0, 1'b1, 32'h01020304, 3'd4};
    tbl[4]  = '{8'hAA, 1'b0, 1'b0, 32'h0,        3'd0};
    tbl[5]  = '{8'hBB, 1'b1, 1'b1, 32'hAABB0000, 3'd2};
    tbl[6]  = '{8'hCC, 1'b1, 1'b1, 32'hCC000000, 3'd1};
    tbl[7]  = '{8'h11, 1'b0, 1'b0, 32'h0,        3'd0};
    tbl[8]  = '{8'h22, 1'b0, 1'b0, 32'h0,        3'd0};
    tbl[9]  = '{8'h33, 1'b0, 1'b0, 32'h0,        3'd0};
    tbl[10] = '{8'h44, 1'b1, 1'b1, 32'h11223344, 3'd4};
    tbl[11] = '{8'h80, 1'b1, 1'b1, 32'h80000000, 3'd1};

    rst = 1'b1;
    in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    d1_in_valid = 1'b0; d1_in_last = 1'b0; d1_in_data = '0; d1_out_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_out_count", out_count, 3'd0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst1_out_valid", d1_out_valid, 1'b0);
    rst = 1'b0;

    // Directed vectors with the consumer always ready.
    for (int i = 0; i < 12; i++) begin
      step(1'b1, tbl[i].d, tbl[i].l, 1'b1);
      check($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].ev);
      check($sformatf("tbl%0d_in_ready", i), in_ready, 1'b1);
      if (tbl[i].ev) begin
        check($sformatf("tbl%0d_out_data", i), out_data, tbl[i].ed);
        check($sformatf("tbl%0d_out_count", i), out_count, tbl[i].ec);
      end
    end

    // Backpressure: the first vector sits on the output and the second is
    // parked, so the ninth beat must not be taken.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
      if (i == 3) check("bp_first_data", out_data, 32'h10111213);
    end
    check("bp_in_ready_low", in_ready, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 8'h18, 1'b0, 1'b0);
      check("bp_stall_in_ready", in_ready, 1'b0);
      check("bp_stable_data", out_data, 32'h10111213);
      check("bp_stable_valid", out_valid, 1'b1);
      check("bp_stable_count", out_count, 3'd4);
    end
    step(1'b1, 8'h18, 1'b0, 1'b1);
    check("bp_second_valid", out_valid, 1'b1);
    check("bp_second_data", out_data, 32'h14151617);
    check("bp_second_count", out_count, 3'd4);
    check("bp_in_ready_back", in_ready, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("bp_drained", out_valid, 1'b0);
    step(1'b1, 8'h99, 1'b1, 1'b1);
    check("bp_slot0_data", out_data, 32'h99000000);
    check("bp_slot0_count", out_count, 3'd1);

    // Reset in the middle of a fill.
    step(1'b1, 8'h55, 1'b0, 1'b1);
    step(1'b1, 8'h66, 1'b0, 1'b1);
    rst = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b1);
    rst = 1'b0;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_data", out_data, 32'h0);
    check("mid_rst_count", out_count, 3'd0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0, 1'b1);
    check("post_rst_data", out_data, 32'h01020304);
    check("post_rst_count", out_count, 3'd4);

    // Reset while a vector is parked.
    for (int i = 0; i < 8; i++) step(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
    check("held_pre_rst", in_ready, 1'b0);
    rst = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    check("held_rst_valid", out_valid, 1'b0);
    check("held_rst_in_ready", in_ready, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("held_rst_no_emit", out_valid, 1'b0);
    step(1'b1, 8'h42, 1'b1, 1'b1);
    check("held_rst_after_data", out_data, 32'h42000000);
    check("held_rst_after_count", out_count, 3'd1);

    // NUM=1 instance: every beat is a complete vector.
    do_reset();
    d1_out_ready = 1'b1;
    begin
      logic [7:0] d1_seq[3];
      d1_seq[0] = 8'h7F; d1_seq[1] = 8'h80; d1_seq[2] = 8'h01;
      for (int i = 0; i < 3; i++) begin
        d1_in_valid = 1'b1; d1_in_data = d1_seq[i]; d1_in_last = 1'b0;
        @(posedge clk); #1;
        check($sformatf("n1_valid%0d", i), d1_out_valid, 1'b1);
        check($sformatf("n1_data%0d", i), d1_out_data, d1_seq[i]);
        check($sformatf("n1_count%0d", i), d1_out_count, 1'b1);
        check($sformatf("n1_in_ready%0d", i), d1_in_ready, 1'b1);
      end
      d1_in_valid = 1'b0;
      @(posedge clk); #1;
      check("n1_drained", d1_out_valid, 1'b0);
    end

    // Full-rate throughput: 40 beats give 10 vectors, one every 4 cycles.
    do_reset();
    xfer_seen = 0;
    ops_acc   = 0;
    for (int i = 0; i < 40; i++) model_cycle(1'b1, 8'($urandom), 1'b0, 1'b1);
    model_cycle(1'b0, 8'h00, 1'b0, 1'b1);
    check("throughput_vectors", 32'(xfer_seen), 32'd10);

    // Random throttling against the queue model.
    ops_acc = 0;
    for (int cyc = 0; cyc < 60000 && ops_acc < 10000; cyc++) begin
      model_cycle($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 5) == 0,
                  $urandom_range(0, 3) != 0);
    end
    check("random_ops_done", 32'(ops_acc >= 10000), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
